// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider.
//   DIV_WIDTH           default operand/result width
//   DIV/DIVU/REM/REMU   divControl encodings
//                       bit 0 = unsigned, bit 1 = remainder
//   divState_t          controller state encoding
//   is_signed_op        helper: decodes the signedness of an operation
//   is_rem_op           helper: decodes whether the remainder is returned
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] DIV  = 2'b00;
    localparam logic [1:0] DIVU = 2'b01;
    localparam logic [1:0] REM  = 2'b10;
    localparam logic [1:0] REMU = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } divState_t;

    function automatic logic is_signed_op(input logic [1:0] ctrl);
        return ~ctrl[0];
    endfunction

    function automatic logic is_rem_op(input logic [1:0] ctrl);
        return ctrl[1];
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
// Ports:
//   rem, quo         current partial remainder / quotient shift register
//   divisor          divisor magnitude
//   rem_next         partial remainder after this iteration
//   quo_next         quotient after this iteration
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // The shifted remainder can be up to 2*divisor-1, so it needs one extra bit.
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;

    assign w_shifted = {rem, quo[WIDTH-1]};
    assign w_fits    = (w_shifted >= {1'b0, divisor});
    // When the trial fits, the difference is below the divisor, so the
    // truncated subtraction is exact.
    assign w_diff    = w_shifted[WIDTH-1:0] - divisor;

    assign rem_next  = w_fits ? w_diff : w_shifted[WIDTH-1:0];
    assign quo_next  = {quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/div_controller.sv
// Multi-cycle divide/remainder unit for a pipelined core.
// The unit stalls the pipeline while a division is running.
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-high reset
//   start          divide/remainder instruction decoded
//   divControl     operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   A, B           dividend / divisor (captured when start is accepted)
//   stall          hold the PC and suppress regWrite while high
//   done           one-cycle pulse; the result is valid and the instruction retires
//   divResult      quotient or remainder; held until the next result is ready
module div_controller
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       divControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] divResult
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   ITERS    = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    divState_t        r_state;
    logic [1:0]       r_ctrl;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;

    logic             w_signed;
    logic             w_is_rem;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_div_zero;
    logic             w_overflow;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    // Sign handling uses the latched operands, which stay stable for the whole operation.
    assign w_signed   = is_signed_op(r_ctrl);
    assign w_is_rem   = is_rem_op(r_ctrl);
    assign w_a_neg    = w_signed & r_a[WIDTH-1];
    assign w_b_neg    = w_signed & r_b[WIDTH-1];
    assign w_a_mag    = w_a_neg ? -r_a : r_a;
    assign w_b_mag    = w_b_neg ? -r_b : r_b;
    assign w_div_zero = (r_b == '0);
    assign w_overflow = w_signed && (r_a == MOST_NEG) && (r_b == '1);

    // The quotient sign follows XOR of the operand signs; the remainder takes the dividend's sign.
    assign w_q_fix    = (w_a_neg ^ w_b_neg) ? -r_quo : r_quo;
    assign w_r_fix    = w_a_neg ? -r_rem : r_rem;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .divisor  (r_div),
        .rem_next (w_rem_next),
        .quo_next (w_quo_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ctrl   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ctrl  <= divControl;
                        r_a     <= A;
                        r_b     <= B;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_quo <= w_a_mag;
                    r_div <= w_b_mag;
                    r_rem <= '0;
                    r_cnt <= ITERS;
                    // Special cases skip the iterations and produce the result directly.
                    if (w_div_zero) begin
                        r_result <= w_is_rem ? r_a : '1;
                        r_state  <= S_DONE;
                    end else if (w_overflow) begin
                        r_result <= w_is_rem ? '0 : r_a;
                        r_state  <= S_DONE;
                    end else begin
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt - CW'(1);
                    // The last iteration takes the counter from 1 to 0.
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_is_rem ? w_r_fix : w_q_fix;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // stall rises in the same cycle as start, so the PC never advances past the instruction.
    assign stall     = ((r_state == S_IDLE) && start) ||
                       (r_state == S_SETUP) || (r_state == S_RUN) || (r_state == S_FIX);
    assign done      = (r_state == S_DONE);
    assign divResult = r_result;

endmodule

// File: tb/tb_div_controller.sv
module tb_div_controller;
    import div_pkg::*;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  divControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        stall;
    logic        done;
    logic [31:0] divResult;

    int n_checks = 0;
    int n_fail   = 0;

    div_controller #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .divControl (divControl),
        .A          (A),
        .B          (B),
        .stall      (stall),
        .done       (done),
        .divResult  (divResult)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
        end
    endtask

    // Reference semantics written directly from the instruction definitions.
    function automatic logic [31:0] ref_div(input logic [1:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [31:0]        q;
        logic [31:0]        r;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (c == DIV || c == REM) begin
            if (a == MIN32 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = 32'd0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return (c == REM || c == REMU) ? r : q;
    endfunction

    function automatic int ref_lat(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 2;
        if ((c == DIV || c == REM) && a == MIN32 && b == 32'hFFFF_FFFF) return 2;
        return 35;
    endfunction

    // Called right after the accepting edge. Returns the number of edges,
    // counted from the accepting edge, at which done is first sampled high.
    // It also returns whether stall stayed high on every busy cycle.
    task automatic track(input bit keep_start, output int lat, output bit stall_ok);
        lat      = -1;
        stall_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k + 1;
                break;
            end
            if (!stall) stall_ok = 1'b0;
            if (keep_start) begin
                A = $urandom;
                B = $urandom;
            end else if (k == 0) begin
                start = 1'b0;
                A     = $urandom;
                B     = $urandom;
            end
            @(posedge clk);
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        bit st_ok;
        divControl = c;
        A          = a;
        B          = b;
        start      = 1'b1;
        #1;
        chk({nm, " stall_with_start"}, {31'd0, stall}, 32'd1);
        @(posedge clk);
        track(1'b0, lat, st_ok);
        chk({nm, " result"}, divResult, exp_r);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " stall_busy"}, {31'd0, st_ok}, 32'd1);
        chk({nm, " stall_in_done"}, {31'd0, stall}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, " done_single_pulse"}, {31'd0, done}, 32'd0);
        chk({nm, " result_held"}, divResult, exp_r);
        $display("op %-10s ctrl=%0d A=%08h B=%08h result=%08h latency=%0d", nm, c, a, b,
                 divResult, lat);
    endtask

    initial begin
        int          lat;
        bit          st_ok;
        logic [1:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        int          sel;

        vecs[0]  = '{DIVU, 32'd100,       32'd7,         32'd14,        35};
        vecs[1]  = '{REMU, 32'd100,       32'd7,         32'd2,         35};
        vecs[2]  = '{DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 35};
        vecs[3]  = '{REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 35};
        vecs[4]  = '{REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         35};
        vecs[5]  = '{DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
        vecs[6]  = '{REMU, 32'd5,         32'd0,         32'd5,         2};
        vecs[7]  = '{DIV,  MIN32,         32'hFFFF_FFFF, MIN32,         2};
        vecs[8]  = '{REM,  MIN32,         32'hFFFF_FFFF, 32'd0,         2};
        vecs[9]  = '{DIV,  32'd0,         32'd5,         32'd0,         35};
        vecs[10] = '{DIVU, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 35};
        vecs[11] = '{DIV,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2,         35};
        vecs[12] = '{REM,  32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 35};
        vecs[13] = '{DIV,  32'd5,         32'd0,         32'hFFFF_FFFF, 2};
        vecs[14] = '{REM,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 2};
        vecs[15] = '{DIVU, MIN32,         32'hFFFF_FFFF, 32'd0,         35};
        vecs[16] = '{REMU, MIN32,         32'hFFFF_FFFF, MIN32,         35};

        reset      = 1'b1;
        start      = 1'b0;
        divControl = 2'b00;
        A          = 32'd0;
        B          = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset divResult", divResult, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].exp,
                   vecs[i].lat);
        end

        for (int i = 0; i < 40; i++) begin
            c   = 2'($urandom_range(0, 3));
            a   = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                b = 32'd0;
            end else if (sel == 1) begin
                a = MIN32;
                b = 32'hFFFF_FFFF;
            end else if (sel <= 4) begin
                b = 32'($urandom_range(1, 15));
            end else if (sel == 5) begin
                b = -32'($urandom_range(1, 15));
            end else begin
                b = $urandom;
            end
            run_op($sformatf("rnd%0d", i), c, a, b, ref_div(c, a, b), ref_lat(c, a, b));
        end

        // Start held through DONE while the operands toggle during RUN.
        divControl = DIVU;
        A          = 32'd1000;
        B          = 32'd7;
        start      = 1'b1;
        @(posedge clk);
        track(1'b1, lat, st_ok);
        chk("hold result_latched", divResult, 32'd142);
        chk("hold latency", 32'(lat), 32'd35);
        chk("hold stall_busy", {31'd0, st_ok}, 32'd1);
        chk("hold stall_in_done", {31'd0, stall}, 32'd0);
        $display("op hold       ctrl=1 A=000003e8 B=00000007 result=%08h latency=%0d", divResult, lat);
        divControl = DIV;
        A          = 32'hFFFF_FF9C;
        B          = 32'd7;
        @(posedge clk);
        @(negedge clk);
        chk("hold done_single_pulse", {31'd0, done}, 32'd0);
        chk("hold stall_idle_start", {31'd0, stall}, 32'd1);
        @(posedge clk);
        track(1'b0, lat, st_ok);
        chk("b2b result", divResult, 32'hFFFF_FFF2);
        chk("b2b latency", 32'(lat), 32'd35);
        chk("b2b stall_busy", {31'd0, st_ok}, 32'd1);
        $display("op b2b        ctrl=0 A=ffffff9c B=00000007 result=%08h latency=%0d", divResult, lat);
        @(posedge clk);
        @(negedge clk);

        // Reset asserted asynchronously in the middle of RUN.
        run_op("pre_reset", DIVU, 32'd100, 32'd7, 32'd14, 35);
        divControl = DIVU;
        A          = 32'd100;
        B          = 32'd7;
        start      = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            A     = $urandom;
            B     = $urandom;
            @(posedge clk);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrun_reset divResult", divResult, 32'd0);
        chk("midrun_reset done", {31'd0, done}, 32'd0);
        chk("midrun_reset stall", {31'd0, stall}, 32'd0);
        $display("op reset      asserted mid-RUN: divResult=%08h stall=%0d done=%0d", divResult,
                 stall, done);
        @(posedge clk);
        @(negedge clk);
        chk("in_reset stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;
        run_op("post_reset", REMU, 32'd100, 32'd7, 32'd2, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_controller.md
DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.
REQ-002 SHALL have one clock; reset is asynchronous and active-high; clock port is clk, reset port is reset.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port: start  input  1  decoded divide/remainder instruction present.
REQ-006 SHALL have port: divControl  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port: A  input  WIDTH  dividend (rs1).
REQ-008 SHALL have port: B  input  WIDTH  divisor (rs2).
REQ-009 SHALL have port: stall  output  1  hold PC and suppress regWrite while high.
REQ-010 SHALL have port: done  output  1  result valid; instruction retires this cycle.
REQ-011 SHALL have port: divResult  output  WIDTH  quotient or remainder per divControl.

Function
REQ-012 SHALL implement the FSM IDLE, SETUP, RUN, FIX, DONE.
REQ-013 SHALL accept start only in IDLE and latch A, B and divControl on that edge; later operand changes SHALL be ignored.
REQ-014 SHALL, in SETUP, take magnitudes (signed ops only), clear the remainder register, and load the iteration counter with WIDTH.
REQ-015 SHALL, in RUN, perform one restoring step per cycle: shift {rem,quo} left 1, trial-subtract divisor magnitude, keep if non-negative, set quotient LSB accordingly, decrement counter.
REQ-016 SHALL go RUN->FIX when the counter reaches 0, after exactly WIDTH RUN cycles.
REQ-017 SHALL, in FIX, negate the quotient if the operand signs differ and negate the remainder if the dividend is negative (signed only), then register divResult.
REQ-018 SHALL go FIX->DONE and DONE->IDLE unconditionally; start seen in DONE SHALL NOT restart.
REQ-019 SHALL, on the normal path, assert done exactly WIDTH+3 edges after the accepting edge (35 for WIDTH=32).
REQ-020 SHALL, for divide-by-zero (B==0), go SETUP->DONE with quotient all-ones and remainder = A; done 2 edges after the accepting edge.
REQ-021 SHALL, for signed overflow (DIV/REM, A=most-negative, B=-1), go SETUP->DONE with quotient = A and remainder = 0.
REQ-022 SHALL drive stall combinationally = (state==IDLE && start) || state in {SETUP, RUN, FIX}; stall SHALL be 0 in DONE.
REQ-023 SHALL drive done = 1 only in DONE (one-cycle pulse per operation).
REQ-024 SHALL hold divResult from DONE until the next result is registered.

Reset
REQ-025 SHALL, on reset assertion (any time, including mid-RUN), enter IDLE immediately; divResult, counter and internal registers SHALL be 0; stall follows REQ-022 and done = 0.
REQ-026 SHALL, on the first edge after reset deassertion with start high, accept the operation normally.

Structure
REQ-027 SHALL place in shared package div_pkg: state enum divState_t, divControl encodings DIV/DIVU/REM/REMU, DIV_WIDTH=32.
REQ-028 SHALL use one sub-module, div_step: a combinational single restoring iteration ({rem,quo}, divisor) -> ({rem',quo'}); everything else SHALL live in div_controller.

Verification
REQ-029 SHALL cover DIVU 100/7: start at edge 0 -> stall high edges 0-34, done in cycle after edge 35, divResult=14; REMU same operands -> 2.
REQ-030 SHALL cover DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-031 SHALL cover DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both with done 2 edges after start.
REQ-032 SHALL cover DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both via the short path.
REQ-033 SHALL cover reset asserted at RUN cycle 10 -> state IDLE, stall 0 (start low), done 0, divResult 0; the next start completes correctly.
REQ-034 SHALL cover start held high through DONE plus A/B toggling mid-RUN -> exactly one done pulse and the result from latched operands; back-to-back start in IDLE runs a second operation.
